// File: rtl/tq_ram_arb_32x16_if.sv
// Requester and RAM-side signal bundle for the two-port RAM arbiter.
// slave is the arbiter's view; master is the view of whoever drives the requests and models the RAM.
interface tq_ram_arb_32x16_if #(
  parameter int DATA_WID = 16,
  parameter int ADDR_WID = 5
);
  logic                a_req_i;
  logic                a_we_i;
  logic                a_lock_i;
  logic [ADDR_WID-1:0] a_addr_i;
  logic [DATA_WID-1:0] a_data_i;
  logic                a_gnt_o;
  logic                a_rvld_o;

  logic                b_req_i;
  logic                b_we_i;
  logic                b_lock_i;
  logic [ADDR_WID-1:0] b_addr_i;
  logic [DATA_WID-1:0] b_data_i;
  logic                b_gnt_o;
  logic                b_rvld_o;

  logic [DATA_WID-1:0] rdata_o;
  logic                ram_cen_o;
  logic                ram_wen_o;
  logic [ADDR_WID-1:0] ram_addr_o;
  logic [DATA_WID-1:0] ram_data_o;
  logic [DATA_WID-1:0] ram_q_i;

  modport slave (
    input  a_req_i, a_we_i, a_lock_i, a_addr_i, a_data_i,
    output a_gnt_o, a_rvld_o,
    input  b_req_i, b_we_i, b_lock_i, b_addr_i, b_data_i,
    output b_gnt_o, b_rvld_o,
    output rdata_o, ram_cen_o, ram_wen_o, ram_addr_o, ram_data_o,
    input  ram_q_i
  );

  modport master (
    output a_req_i, a_we_i, a_lock_i, a_addr_i, a_data_i,
    input  a_gnt_o, a_rvld_o,
    output b_req_i, b_we_i, b_lock_i, b_addr_i, b_data_i,
    input  b_gnt_o, b_rvld_o,
    input  rdata_o, ram_cen_o, ram_wen_o, ram_addr_o, ram_data_o,
    output ram_q_i
  );
endinterface

// File: rtl/tq_ram_arb_32x16.sv
// Two-requester arbiter for a single-port 32x16 RAM: round-robin with burst lock, combinational grant,
// one access per cycle, read-valid pulse registered one cycle after a granted read.
module tq_ram_arb_32x16 #(
  parameter int DATA_WID = 16,
  parameter int ADDR_WID = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  tq_ram_arb_32x16_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   rr_ptr_q, rr_ptr_d;
  logic   a_rvld_q, a_rvld_d;
  logic   b_rvld_q, b_rvld_d;
  logic   a_gnt, b_gnt;
  logic   arb_open;

  logic [ADDR_WID-1:0] ram_addr;
  logic [DATA_WID-1:0] ram_data;
  logic                ram_wen;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    arb_open = 1'b1;

    // A held lock excludes the other side even while the owner is idle.
    case (state_q)
      LOCK_A: begin
        if (bus.a_lock_i) begin
          arb_open = 1'b0;
          a_gnt    = bus.a_req_i;
        end
      end
      LOCK_B: begin
        if (bus.b_lock_i) begin
          arb_open = 1'b0;
          b_gnt    = bus.b_req_i;
        end
      end
      default: ;
    endcase

    if (arb_open) begin
      state_d = IDLE;
      if (bus.a_req_i && (!bus.b_req_i || !rr_ptr_q)) begin
        a_gnt = 1'b1;
      end else if (bus.b_req_i) begin
        b_gnt = 1'b1;
      end
      if (a_gnt && bus.a_lock_i) begin
        state_d = LOCK_A;
      end else if (b_gnt && bus.b_lock_i) begin
        state_d = LOCK_B;
      end
    end

    if (a_gnt) begin
      rr_ptr_d = 1'b1;
    end else if (b_gnt) begin
      rr_ptr_d = 1'b0;
    end

    // Grants vanish the moment reset rises, so no access starts under reset.
    if (rst) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end

    a_rvld_d = a_gnt && !bus.a_we_i;
    b_rvld_d = b_gnt && !bus.b_we_i;
  end

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wen  = 1'b1;
    if (a_gnt) begin
      ram_addr = bus.a_addr_i;
      ram_data = bus.a_data_i;
      ram_wen  = ~bus.a_we_i;
    end else if (b_gnt) begin
      ram_addr = bus.b_addr_i;
      ram_data = bus.b_data_i;
      ram_wen  = ~bus.b_we_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      a_rvld_q <= 1'b0;
      b_rvld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_rvld_q <= a_rvld_d;
      b_rvld_q <= b_rvld_d;
    end
  end

  assign bus.a_gnt_o    = a_gnt;
  assign bus.b_gnt_o    = b_gnt;
  assign bus.a_rvld_o   = a_rvld_q;
  assign bus.b_rvld_o   = b_rvld_q;
  assign bus.rdata_o    = bus.ram_q_i;
  assign bus.ram_cen_o  = ~(a_gnt | b_gnt);
  assign bus.ram_wen_o  = ram_wen;
  assign bus.ram_addr_o = ram_addr;
  assign bus.ram_data_o = ram_data;

endmodule

// File: tb/tb_tq_ram_arb_32x16.sv
// Directed-vector bench for tq_ram_arb_32x16 with a behavioural RAM and a queue-based scoreboard.
module tb_tq_ram_arb_32x16;

  logic clk;
  logic rst;

  tq_ram_arb_32x16_if #(.DATA_WID(16), .ADDR_WID(5)) bus ();

  tq_ram_arb_32x16 #(.DATA_WID(16), .ADDR_WID(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: contents reload to A000+addr while reset is held at a clock edge.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (!bus.ram_cen_o) begin
      if (!bus.ram_wen_o) mem[bus.ram_addr_o] <= bus.ram_data_o;
      else                bus.ram_q_i <= mem[bus.ram_addr_o];
    end
  end

  typedef struct {
    logic        rst;
    logic [2:0]  a_ctl;   // {req, we, lock}
    logic [4:0]  a_addr;
    logic [15:0] a_data;
    logic [2:0]  b_ctl;
    logic [4:0]  b_addr;
    logic [15:0] b_data;
    logic [3:0]  e_flags; // {a_gnt, b_gnt, a_rvld, b_rvld}
    logic        e_cen;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [15:0] e_data;
    logic [15:0] e_rdata;
  } vec_t;

  typedef struct {
    int          idx;
    logic [26:0] ports;
    logic        chk_rdata;
    logic [15:0] rdata;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  task automatic add(input logic r,
                     input logic [2:0] ac, input logic [4:0] aa, input logic [15:0] ad,
                     input logic [2:0] bc, input logic [4:0] ba, input logic [15:0] bd,
                     input logic [3:0] fl, input logic cen, input logic wen,
                     input logic [4:0] ea, input logic [15:0] ed, input logic [15:0] er);
    vec_t v;
    v.rst = r; v.a_ctl = ac; v.a_addr = aa; v.a_data = ad;
    v.b_ctl = bc; v.b_addr = ba; v.b_data = bd;
    v.e_flags = fl; v.e_cen = cen; v.e_wen = wen;
    v.e_addr = ea; v.e_data = ed; v.e_rdata = er;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    rst          = v.rst;
    bus.a_req_i  = v.a_ctl[2];
    bus.a_we_i   = v.a_ctl[1];
    bus.a_lock_i = v.a_ctl[0];
    bus.a_addr_i = v.a_addr;
    bus.a_data_i = v.a_data;
    bus.b_req_i  = v.b_ctl[2];
    bus.b_we_i   = v.b_ctl[1];
    bus.b_lock_i = v.b_ctl[0];
    bus.b_addr_i = v.b_addr;
    bus.b_data_i = v.b_data;
  endtask

  // Driver: one vector per cycle, applied just after the rising edge.
  initial begin
    vec_t idle_v;
    exp_t e;
    rst = 1'b1;
    idle_v = '{rst: 1'b0, a_ctl: 3'b000, a_addr: 5'd0, a_data: 16'h0,
               b_ctl: 3'b000, b_addr: 5'd0, b_data: 16'h0, e_flags: 4'b0000,
               e_cen: 1'b1, e_wen: 1'b1, e_addr: 5'd0, e_data: 16'h0, e_rdata: 16'h0};
    apply(idle_v);
    rst = 1'b1;
    bus.ram_q_i = 16'h0;

    //   rst a_ctl  aa   ad       b_ctl  ba   bd     flags    cen  wen  addr  data     rdata
    add(1, 3'b100, 3,  16'h0,    3'b100, 7,  16'h0, 4'b0000, 1, 1, 0,  16'h0,    16'h0);
    add(0, 3'b100, 3,  16'h0,    3'b100, 7,  16'h0, 4'b1000, 0, 1, 3,  16'h0,    16'h0);
    add(0, 3'b100, 3,  16'h0,    3'b100, 7,  16'h0, 4'b0110, 0, 1, 7,  16'h0,    16'hA003);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0001, 1, 1, 0,  16'h0,    16'hA007);
    add(0, 3'b110, 5,  16'h1234, 3'b000, 0,  16'h0, 4'b1000, 0, 0, 5,  16'h1234, 16'h0);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0000, 1, 1, 0,  16'h0,    16'h0);
    add(0, 3'b100, 5,  16'h0,    3'b000, 0,  16'h0, 4'b1000, 0, 1, 5,  16'h0,    16'h0);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0010, 1, 1, 0,  16'h0,    16'h1234);
    add(0, 3'b000, 0,  16'h0,    3'b100, 9,  16'h0, 4'b0100, 0, 1, 9,  16'h0,    16'h0);
    // A burst of four locked reads while B keeps requesting
    add(0, 3'b101, 0,  16'h0,    3'b100, 10, 16'h0, 4'b1001, 0, 1, 0,  16'h0,    16'hA009);
    add(0, 3'b101, 1,  16'h0,    3'b100, 10, 16'h0, 4'b1010, 0, 1, 1,  16'h0,    16'hA000);
    add(0, 3'b101, 2,  16'h0,    3'b100, 10, 16'h0, 4'b1010, 0, 1, 2,  16'h0,    16'hA001);
    add(0, 3'b101, 3,  16'h0,    3'b100, 10, 16'h0, 4'b1010, 0, 1, 3,  16'h0,    16'hA002);
    add(0, 3'b100, 4,  16'h0,    3'b100, 10, 16'h0, 4'b0110, 0, 1, 10, 16'h0,    16'hA003);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0001, 1, 1, 0,  16'h0,    16'hA00A);
    // B takes the lock, then idles while A is shut out
    add(0, 3'b000, 0,  16'h0,    3'b101, 11, 16'h0, 4'b0100, 0, 1, 11, 16'h0,    16'h0);
    add(0, 3'b100, 6,  16'h0,    3'b001, 0,  16'h0, 4'b0001, 1, 1, 0,  16'h0,    16'hA00B);
    add(0, 3'b100, 6,  16'h0,    3'b001, 0,  16'h0, 4'b0000, 1, 1, 0,  16'h0,    16'h0);
    add(0, 3'b100, 6,  16'h0,    3'b001, 0,  16'h0, 4'b0000, 1, 1, 0,  16'h0,    16'h0);
    add(0, 3'b100, 6,  16'h0,    3'b000, 0,  16'h0, 4'b1000, 0, 1, 6,  16'h0,    16'h0);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0010, 1, 1, 0,  16'h0,    16'hA006);
    // Lock without request must not claim the RAM
    add(0, 3'b001, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0000, 1, 1, 0,  16'h0,    16'h0);
    add(0, 3'b001, 0,  16'h0,    3'b100, 12, 16'h0, 4'b0100, 0, 1, 12, 16'h0,    16'h0);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0001, 1, 1, 0,  16'h0,    16'hA00C);
    // Reset lands mid LOCK_A burst
    add(0, 3'b101, 13, 16'h0,    3'b100, 14, 16'h0, 4'b1000, 0, 1, 13, 16'h0,    16'h0);
    add(0, 3'b101, 14, 16'h0,    3'b100, 14, 16'h0, 4'b1010, 0, 1, 14, 16'h0,    16'hA00D);
    add(1, 3'b101, 15, 16'h0,    3'b100, 16, 16'h0, 4'b0000, 1, 1, 0,  16'h0,    16'h0);
    add(0, 3'b100, 15, 16'h0,    3'b100, 16, 16'h0, 4'b1000, 0, 1, 15, 16'h0,    16'h0);
    add(0, 3'b100, 17, 16'h0,    3'b100, 18, 16'h0, 4'b0110, 0, 1, 18, 16'h0,    16'hA00F);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0001, 1, 1, 0,  16'h0,    16'hA012);
    add(0, 3'b000, 0,  16'h0,    3'b000, 0,  16'h0, 4'b0000, 1, 1, 0,  16'h0,    16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      e.idx       = i;
      e.ports     = {vecs[i].e_flags, vecs[i].e_cen, vecs[i].e_wen,
                     vecs[i].e_addr, vecs[i].e_data};
      e.chk_rdata = vecs[i].e_flags[1] | vecs[i].e_flags[0];
      e.rdata     = vecs[i].e_rdata;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    apply(idle_v);
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  // Monitor: compares the DUT outputs of each cycle against the queued expectation.
  initial begin
    exp_t        e;
    logic [26:0] got;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.a_gnt_o, bus.b_gnt_o, bus.a_rvld_o, bus.b_rvld_o,
               bus.ram_cen_o, bus.ram_wen_o, bus.ram_addr_o, bus.ram_data_o};
        checks++;
        if (got !== e.ports) begin
          errors++;
          $display("FAIL vec%0d ports {gnt,rvld,cen,wen,addr,data} got %h exp %h",
                   e.idx, got, e.ports);
        end
        if (e.chk_rdata) begin
          checks++;
          if (bus.rdata_o !== e.rdata) begin
            errors++;
            $display("FAIL vec%0d rdata got %h exp %h", e.idx, bus.rdata_o, e.rdata);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tq_ram_arb_32x16.md
TQ_RAM_ARB_32X16 -- requirements
Module: tq_ram_arb_32x16

Interface
REQ-001 The block SHALL have parameter DATA_WID, default 16, meaning the RAM word width.
REQ-002 The block SHALL have parameter ADDR_WID, default 5, meaning the RAM address width (32 words).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port a_req_i  input  1  requester A access request.
REQ-007 Port a_we_i  input  1  requester A write (1) or read (0).
REQ-008 Port a_lock_i  input  1  requester A burst lock.
REQ-009 Port a_addr_i  input  ADDR_WID  requester A address.
REQ-010 Port a_data_i  input  DATA_WID  requester A write data.
REQ-011 Port a_gnt_o  output  1  requester A granted this cycle.
REQ-012 Port a_rvld_o  output  1  requester A read data valid on rdata_o.
REQ-013 Ports b_req_i, b_we_i, b_lock_i, b_addr_i, b_data_i, b_gnt_o, b_rvld_o SHALL mirror REQ-006..012 for requester B.
REQ-014 Port rdata_o  output  DATA_WID  read data, driven directly from ram_q_i.
REQ-015 Port ram_cen_o  output  1  RAM chip enable, low active.
REQ-016 Port ram_wen_o  output  1  RAM write enable, low active.
REQ-017 Port ram_addr_o  output  ADDR_WID  RAM address.
REQ-018 Port ram_data_o  output  DATA_WID  RAM write data.
REQ-019 Port ram_q_i  input  DATA_WID  RAM read data, valid one cycle after a read access.

Function
REQ-020 Grants SHALL be combinational from the requests and the registered state; at most one of a_gnt_o and b_gnt_o SHALL be high in any cycle.
REQ-021 When a requester is granted, ram_cen_o SHALL be 0, ram_wen_o SHALL be ~x_we_i, and ram_addr_o/ram_data_o SHALL pass through that requester's address and data.
REQ-022 With no grant: ram_cen_o=1, ram_wen_o=1, ram_addr_o=0, ram_data_o=0.
REQ-023 The FSM SHALL have states IDLE, LOCK_A and LOCK_B.
REQ-024 IDLE: sole requester wins; if both request, the winner is the one named by the registered pointer rr_ptr (0=A, 1=B).
REQ-025 IDLE: after a granted access by X, rr_ptr SHALL point to the other requester.
REQ-026 IDLE -> LOCK_X when X is granted with x_lock_i=1.
REQ-027 LOCK_X: only X SHALL be granted, when x_req_i=1; the other requester SHALL never be granted, even with X idle.
REQ-028 LOCK_X with x_lock_i=0 SHALL arbitrate that same cycle as IDLE (rr_ptr already pointing to the other requester) and SHALL return to IDLE.
REQ-029 x_rvld_o SHALL be a registered one-cycle pulse, asserted in the cycle after a granted read by X; a granted write SHALL NOT produce rvld.
REQ-030 Back-to-back reads SHALL yield rvld on consecutive cycles, at one access per cycle throughput.
REQ-031 Asserting x_lock_i without x_req_i in IDLE SHALL have no effect.

Reset
REQ-032 While rst=1: state=IDLE, rr_ptr=0, a_rvld_o=b_rvld_o=0, both grants 0, ram_cen_o=1, ram_wen_o=1.
REQ-033 Reset asserted mid-burst SHALL abort the lock immediately; no rvld SHALL be issued for a read granted in the cycle reset asserts.

Verification
REQ-034 Reset release, both requesting reads at addresses 3 (A) and 7 (B) -> A granted cycle 0 with ram_addr_o=3; B granted cycle 1 with ram_addr_o=7; a_rvld_o in cycle 1; b_rvld_o in cycle 2.
REQ-035 A writes 0x1234 to address 5 alone -> ram_cen_o=0, ram_wen_o=0, ram_data_o=0x1234 for one cycle; no rvld.
REQ-036 A locks for 4 reads while B requests continuously -> 4 consecutive A grants; b_gnt_o=0; B granted in the first cycle after a_lock_i drops.
REQ-037 LOCK_B with b_req_i=0 and a_req_i=1 for 3 cycles -> no grants, ram_cen_o=1 in those cycles.
REQ-038 rst pulsed during a LOCK_A read burst -> outputs return to REQ-032 values asynchronously; after release, both requesting -> A granted first.
